// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Small ALU with a single-cycle path for logic/add/sub/compare and an
//   optional iterative shift-add multiplier. Every accepted operation ends
//   with a one-cycle done_o pulse, after which the result is held.
//
// Ports
//   clk_i   : sole clock, rising edge
//   rst_i   : synchronous active-high reset
//   start_i : request, accepted only while busy_o=0
//   a_i,b_i : operands (WIDTH bits)
//   ctrl_i  : 000 AND, 001 OR, 010 ADD, 110 SUB, 100 MUL, 111 SLT
//   busy_o  : iterative multiply in progress
//   done_o  : one-cycle pulse, result valid
//   res_o   : registered result, held until the next done_o
//   zero_o  : res_o == 0, registered with res_o
//   ovf_o   : signed overflow of ADD/SUB, otherwise 0
module multicycle_alu #(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       ctrl_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o,
   output logic             zero_o,
   output logic             ovf_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b111;

   // Single-cycle result; returns {ovf, res}. MUL only lands here in the
   // fast configuration, so the multiplier folds away otherwise.
   function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [2:0]       op);
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      logic [WIDTH-1:0]        r;
      logic                    v;
      sa = a;
      sb = b;
      r  = '0;
      v  = 1'b0;
      case (op)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_ADD: begin
            r = a + b;
            v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            r = a - b;
            v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL: if (FAST_MUL) r = a * b;
         OP_SLT: r = {{(WIDTH-1){1'b0}}, (sa < sb)};
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] acc_step;
   logic             busy;
   logic             accept;

   assign busy   = (state_q == S_MUL);
   assign accept = start_i & ~busy;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      res_d    = res_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
      case (state_q)
         // DONE behaves like IDLE so single-cycle ops can issue back to back
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               if ((ctrl_i == OP_MUL) && !FAST_MUL) begin
                  state_d  = S_MUL;
                  cnt_d    = CNT_W'(WIDTH);
                  mcand_d  = a_i;
                  mplier_d = b_i;
                  acc_d    = '0;
               end else begin
                  state_d        = S_DONE;
                  {ovf_d, res_d} = alu_f(a_i, b_i, ctrl_i);
                  zero_d         = (res_d == '0);
               end
            end
         end
         // One multiplier bit per cycle; the last iteration writes the result
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
               res_d   = acc_step;
               zero_d  = (acc_step == '0);
               ovf_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   // Multiplier datapath is always reloaded on accept, so it needs no reset
   always_ff @(posedge clk_i) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

   assign busy_o = busy;
   assign done_o = (state_q == S_DONE);
   assign res_o  = res_q;
   assign zero_o = zero_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

   localparam int W = 32;

   logic          clk;
   logic          rst;
   logic          st  [2];
   logic [W-1:0]  av  [2];
   logic [W-1:0]  bv  [2];
   logic [2:0]    cv  [2];
   logic          busy[2];
   logic          done[2];
   logic [W-1:0]  res [2];
   logic          zero[2];
   logic          ovf [2];

   int n_chk;
   int n_fail;

   // index 0: iterative multiplier, index 1: single-cycle multiplier
   multicycle_alu #(.WIDTH(W), .FAST_MUL(1'b0)) dut_slow (
      .clk_i(clk), .rst_i(rst), .start_i(st[0]), .a_i(av[0]), .b_i(bv[0]),
      .ctrl_i(cv[0]), .busy_o(busy[0]), .done_o(done[0]), .res_o(res[0]),
      .zero_o(zero[0]), .ovf_o(ovf[0]));

   multicycle_alu #(.WIDTH(W), .FAST_MUL(1'b1)) dut_fast (
      .clk_i(clk), .rst_i(rst), .start_i(st[1]), .a_i(av[1]), .b_i(bv[1]),
      .ctrl_i(cv[1]), .busy_o(busy[1]), .done_o(done[1]), .res_o(res[1]),
      .zero_o(zero[1]), .ovf_o(ovf[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result from plain integer arithmetic: {ovf, res}
   function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
      longint sa, sb, t;
      logic [63:0] p;
      logic [W-1:0] r;
      logic v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      t = 0;
      r = '0;
      v = 1'b0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: begin t = sa + sb; r = t[W-1:0]; v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         3'b110: begin t = sa - sb; r = t[W-1:0]; v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         3'b100: begin p = 64'(a) * 64'(b); r = p[W-1:0]; end
         3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   // Behavioural model: an accepted op completes after a fixed latency
   bit          mv;
   int          rem  [2];
   int          acc  [2];
   logic [W:0]  pend [2];
   logic [W-1:0] m_res[2];
   bit          m_zero[2], m_ovf[2], m_done[2], m_busy[2];

   initial begin
      mv = 0;
      for (int d = 0; d < 2; d++) begin
         rem[d] = 0; acc[d] = 0; pend[d] = '0; m_res[d] = '0;
         m_zero[d] = 1; m_ovf[d] = 0; m_done[d] = 0; m_busy[d] = 0;
      end
      forever begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               mv = 1;
               rem[d] = 0; m_done[d] = 0; m_busy[d] = 0;
               m_res[d] = '0; m_zero[d] = 1; m_ovf[d] = 0;
            end else begin
               m_done[d] = 0;
               if (rem[d] == 0 && st[d] === 1'b1) begin
                  acc[d]++;
                  pend[d] = ref_op(av[d], bv[d], cv[d]);
                  rem[d] = (d == 0 && cv[d] == 3'b100) ? W + 1 : 1;
               end
               if (rem[d] > 0) begin
                  rem[d]--;
                  if (rem[d] == 0) begin
                     m_done[d] = 1;
                     m_res[d]  = pend[d][W-1:0];
                     m_ovf[d]  = pend[d][W];
                     m_zero[d] = (pend[d][W-1:0] == 0);
                  end
               end
               m_busy[d] = (rem[d] > 0);
            end
         end
      end
   end

   // Compare every cycle once the model has seen a reset
   initial begin
      forever begin
         @(negedge clk);
         if (mv) begin
            for (int d = 0; d < 2; d++) begin
               chk($sformatf("d%0d_done", d), 64'(done[d]), 64'(m_done[d]));
               chk($sformatf("d%0d_busy", d), 64'(busy[d]), 64'(m_busy[d]));
               chk($sformatf("d%0d_res",  d), 64'(res[d]),  64'(m_res[d]));
               chk($sformatf("d%0d_zero", d), 64'(zero[d]), 64'(m_zero[d]));
               chk($sformatf("d%0d_ovf",  d), 64'(ovf[d]),  64'(m_ovf[d]));
            end
         end
      end
   end

   task automatic drive_both(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
      for (int d = 0; d < 2; d++) begin
         st[d] = 1'b1; av[d] = a; bv[d] = b; cv[d] = c;
      end
   endtask

   task automatic idle_both();
      st[0] = 1'b0;
      st[1] = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int cyc, bcnt, dcnt;
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         st[d] = 1'b0; av[d] = '0; bv[d] = '0; cv[d] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy[0]), 64'd0);
      chk("rst_done", 64'(done[0]), 64'd0);
      chk("rst_res",  64'(res[0]),  64'd0);
      chk("rst_zero", 64'(zero[0]), 64'd1);
      chk("rst_ovf",  64'(ovf[0]),  64'd0);

      // start coincident with reset is dropped
      drive_both(32'd1, 32'd2, 3'b010);
      @(negedge clk);
      idle_both();
      rst = 1'b0;
      chk("rst_start_done", 64'(done[1]), 64'd0);
      chk("rst_start_res",  64'(res[1]),  64'd0);

      // ADD overflow at the positive limit
      @(negedge clk);
      drive_both(32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
      @(negedge clk);
      idle_both();
      chk("add_done", 64'(done[0]), 64'd1);
      chk("add_res",  64'(res[0]),  64'h8000_0000);
      chk("add_ovf",  64'(ovf[0]),  64'd1);
      chk("add_zero", 64'(zero[0]), 64'd0);

      // SUB to zero
      drive_both(32'd5, 32'd5, 3'b110);
      @(negedge clk);
      idle_both();
      chk("sub_res",  64'(res[0]),  64'd0);
      chk("sub_zero", 64'(zero[0]), 64'd1);
      chk("sub_ovf",  64'(ovf[0]),  64'd0);

      // SLT with a negative left operand
      drive_both(32'hFFFF_FFFF, 32'd0, 3'b111);
      @(negedge clk);
      idle_both();
      chk("slt_res", 64'(res[0]), 64'd1);

      // MUL: fast completes next cycle, slow iterates WIDTH cycles
      drive_both(32'h0001_0001, 32'h0001_0001, 3'b100);
      @(negedge clk);
      idle_both();
      chk("fmul_done", 64'(done[1]), 64'd1);
      chk("fmul_res",  64'(res[1]),  64'h0002_0001);
      cyc = 1;
      bcnt = 0;
      while (done[0] !== 1'b1 && cyc < 100) begin
         if (busy[0] === 1'b1) bcnt++;
         st[0] = (cyc == 5 || cyc == 6 || cyc == 20);
         av[0] = 32'd3; bv[0] = 32'd3;
         cv[0] = (cyc == 6) ? 3'b010 : 3'b100;
         @(negedge clk);
         st[0] = 1'b0;
         cyc++;
      end
      chk("smul_latency", 64'(cyc),    64'd33);
      chk("smul_busycnt", 64'(bcnt),   64'd32);
      chk("smul_res",     64'(res[0]), 64'h0002_0001);
      @(negedge clk);
      chk("smul_no_requeue", 64'(done[0]), 64'd0);

      // Reset in the middle of a slow multiply
      drive_both(32'h0000_1234, 32'h0000_5678, 3'b100);
      @(negedge clk);
      idle_both();
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy[0]), 64'd0);
      chk("abort_res",  64'(res[0]),  64'd0);
      chk("abort_zero", 64'(zero[0]), 64'd1);
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done[0] === 1'b1) dcnt++;
      end
      chk("abort_no_done", 64'(dcnt), 64'd0);

      // Back-to-back AND, OR, illegal
      drive_both(32'hF0F0_00FF, 32'h0FF0_F00F, 3'b000);
      @(negedge clk);
      chk("b2b_and_done", 64'(done[0]), 64'd1);
      chk("b2b_and_res",  64'(res[0]),  64'h00F0_000F);
      drive_both(32'hF0F0_00FF, 32'h0FF0_F00F, 3'b001);
      @(negedge clk);
      chk("b2b_or_done", 64'(done[0]), 64'd1);
      chk("b2b_or_res",  64'(res[0]),  64'hFFF0_F0FF);
      drive_both(32'hF0F0_00FF, 32'h0FF0_F00F, 3'b011);
      @(negedge clk);
      idle_both();
      chk("b2b_ill_done", 64'(done[0]), 64'd1);
      chk("b2b_ill_res",  64'(res[0]),  64'd0);
      chk("b2b_ill_zero", 64'(zero[0]), 64'd1);
      chk("b2b_ill_ovf",  64'(ovf[0]),  64'd0);
      @(negedge clk);
      chk("b2b_after_done", 64'(done[0]), 64'd0);
      chk("b2b_hold_zero",  64'(zero[0]), 64'd1);

      // Randomized traffic on both configurations, checked by the model
      acc[0] = 0;
      acc[1] = 0;
      cyc = 0;
      while ((acc[0] < 1000 || acc[1] < 1000) && cyc < 40000) begin
         for (int d = 0; d < 2; d++) begin
            st[d] = ($urandom_range(0, 3) != 0);
            av[d] = rnd_operand();
            bv[d] = rnd_operand();
            cv[d] = 3'($urandom_range(0, 7));
         end
         rst = ($urandom_range(0, 599) == 0);
         @(negedge clk);
         cyc++;
      end
      if (acc[0] < 1000 || acc[1] < 1000) begin
         n_chk++;
         n_fail++;
         $display("FAIL random_budget: accepted %0d/%0d ops, required 1000 each", acc[0], acc[1]);
      end
      idle_both();
      rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
